weapons_fire_controller: RTL and testbench

WEAPONS_FIRE_CONTROLLER -- requirements
Module: weapons_fire_controller

---
 rtl/weapons_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/weapons_fire_controller.sv | 127 ++++++++++++
 tb/tb_weapons_fire_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/weapons_pkg.sv
// Shared definitions for the weapons fire controller: FSM encoding,
// ship mode constants and default datapath sizing.
package weapons_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 2'b00;
    localparam fsm_state_t ST_FIRE   = 2'b01;
    localparam fsm_state_t ST_COOL   = 2'b10;
    localparam fsm_state_t ST_RELOAD = 2'b11;

    localparam logic [3:0] MODE_ATTACK = 4'b0010;

    localparam int DEFAULT_W        = 9;
    localparam int DEFAULT_MAX_AMMO = 500;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: grants the first active request at or
// after the pointer, wrapping around the request vector.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weapons_fire_controller.sv
// Magazine-sharing fire controller: arbitrates turret fire requests,
// enforces cooldown and reload timing, and flags illegal fire attempts.
module weapons_fire_controller
    import weapons_pkg::*;
#(
    parameter int N_TURRET      = 3,
    parameter int W             = DEFAULT_W,
    parameter int MAX_AMMO      = DEFAULT_MAX_AMMO,
    parameter int COOLDOWN      = 2,
    parameter int RELOAD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          mode_selector,
    input  logic [N_TURRET-1:0] fire_req,
    input  logic [W-1:0]        fire_rate,
    input  logic                reload_req,
    input  logic [W-1:0]        reload_amount,
    output logic [N_TURRET-1:0] fire_gnt,
    output logic [W-1:0]        ammo_count,
    output logic [1:0]          state,
    output logic                error
);

    localparam int PTR_W   = (N_TURRET > 1) ? $clog2(N_TURRET) : 1;
    localparam int CNT_MAX = (COOLDOWN > RELOAD_CYCLES) ? COOLDOWN : RELOAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [CNT_W-1:0]    cnt;
    logic [W-1:0]        eff_rate;
    logic [W-1:0]        rate_lat;
    logic [N_TURRET-1:0] arb_gnt;
    logic                arb_vld;
    logic                fire_ok;
    logic                illegal;

    // Widened add so a large reload cannot wrap before the magazine clamp.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > (W+1)'(MAX_AMMO))
            return W'(MAX_AMMO);
        return sum[W-1:0];
    endfunction

    rr_arbiter #(
        .N     (N_TURRET),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (fire_req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .valid (arb_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_TURRET; i++)
            if (arb_gnt[i]) win_idx = PTR_W'(i);
    end

    assign next_ptr = (win_idx == PTR_W'(N_TURRET - 1)) ? '0 : win_idx + 1'b1;
    assign eff_rate = (fire_rate == '0) ? W'(1) : fire_rate;
    assign fire_ok  = arb_vld && (mode_selector == MODE_ATTACK) && (ammo_count >= eff_rate);

    assign illegal = (|fire_req) &&
                     ((mode_selector != MODE_ATTACK) ||
                      (state == ST_RELOAD) ||
                      ((state == ST_IDLE) && (ammo_count < eff_rate) && !reload_req));

    // Shot size is only consumed after a grant out of IDLE, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) rate_lat <= eff_rate;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ammo_count <= '0;
            fire_gnt   <= '0;
            error      <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            error    <= illegal;
            fire_gnt <= '0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (reload_req) begin
                        state <= ST_RELOAD;
                    end else if (fire_ok) begin
                        state    <= ST_FIRE;
                        fire_gnt <= arb_gnt;
                        ptr      <= next_ptr;
                    end
                end
                ST_FIRE: begin
                    ammo_count <= ammo_count - rate_lat;
                    cnt        <= '0;
                    state      <= (COOLDOWN > 0) ? ST_COOL : ST_IDLE;
                end
                ST_COOL: begin
                    if (cnt == CNT_W'(COOLDOWN - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CNT_W'(RELOAD_CYCLES - 1)) begin
                        ammo_count <= sat_add(ammo_count, reload_amount);
                        state      <= ST_IDLE;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weapons_fire_controller.sv
// Directed self-checking bench for weapons_fire_controller.
module tb_weapons_fire_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mode_selector;
    logic [2:0] fire_req;
    logic [8:0] fire_rate;
    logic       reload_req;
    logic [8:0] reload_amount;
    logic [2:0] fire_gnt;
    logic [8:0] ammo_count;
    logic [1:0] state;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    weapons_fire_controller #(
        .N_TURRET      (3),
        .W             (9),
        .MAX_AMMO      (500),
        .COOLDOWN      (2),
        .RELOAD_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_selector (mode_selector),
        .fire_req      (fire_req),
        .fire_rate     (fire_rate),
        .reload_req    (reload_req),
        .reload_amount (reload_amount),
        .fire_gnt      (fire_gnt),
        .ammo_count    (ammo_count),
        .state         (state),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full reload from IDLE: four RELOAD cycles, then IDLE with the expected fill.
    task automatic do_reload(input logic [8:0] amt, input logic [8:0] exp_ammo);
        reload_req    = 1'b1;
        reload_amount = amt;
        step();
        check_eq("reload_enter", state, 2'b11);
        reload_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("reload_hold", state, 2'b11);
        end
        step();
        check_eq("reload_exit_state", state, 2'b00);
        check_eq("reload_exit_ammo", ammo_count, exp_ammo);
    endtask

    initial begin
        logic [2:0] exp_gnt [4];
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;

        rst = 1'b0; mode_selector = 4'b0000; fire_req = '0; fire_rate = '0;
        reload_req = 1'b0; reload_amount = '0;
        step();
        step();
        check_eq("rst_state", state, 2'b00);
        check_eq("rst_ammo", ammo_count, 0);
        check_eq("rst_gnt", fire_gnt, 0);
        check_eq("rst_error", error, 0);

        // Fill the magazine from empty
        rst = 1'b1;
        do_reload(9'd500, 9'd500);

        // Round-robin bursts with cooldown between shots
        mode_selector = 4'b0010; fire_rate = 9'd5; fire_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr_fire_state", state, 2'b01);
            check_eq("rr_gnt", fire_gnt, exp_gnt[k]);
            if (k == 3) fire_req = '0;
            step();
            check_eq("rr_cool_state", state, 2'b10);
            check_eq("rr_cool_gnt", fire_gnt, 0);
            check_eq("rr_ammo", ammo_count, 500 - 5 * (k + 1));
            step();
            check_eq("rr_cool2_state", state, 2'b10);
            step();
            check_eq("rr_idle_state", state, 2'b00);
        end

        // Low ammo: fire blocked, error every IDLE cycle; also reload amount sampled late
        rst = 1'b0;
        step();
        rst = 1'b1;
        reload_req = 1'b1; reload_amount = 9'd100;
        step();
        reload_req = 1'b0;
        step();
        reload_amount = 9'd3;
        step(); step(); step();
        check_eq("late_amount_ammo", ammo_count, 3);
        fire_req = 3'b001; fire_rate = 9'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("low_state", state, 2'b00);
            check_eq("low_gnt", fire_gnt, 0);
            check_eq("low_error", error, 1);
            check_eq("low_ammo", ammo_count, 3);
        end
        fire_req = '0;
        step();
        check_eq("low_error_clear", error, 0);

        // Reload past capacity clamps to the magazine size
        do_reload(9'd500, 9'd500);

        // Wrong mode: illegal fire
        mode_selector = 4'b0001; fire_req = 3'b010;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("mode_error", error, 1);
            check_eq("mode_gnt", fire_gnt, 0);
            check_eq("mode_state", state, 2'b00);
            check_eq("mode_ammo", ammo_count, 500);
        end
        mode_selector = 4'b0010; fire_req = '0;

        // Bring ammo to 450 with a 50-round shot from turret 0
        fire_req = 3'b001; fire_rate = 9'd50;
        step();
        check_eq("shot50_gnt", fire_gnt, 3'b001);
        fire_req = '0;
        step();
        check_eq("shot50_ammo", ammo_count, 450);
        step(); step();
        check_eq("shot50_idle", state, 2'b00);

        // Reload and fire together: reload wins, fire during reload flagged
        reload_req = 1'b1; fire_req = 3'b100; reload_amount = 9'd200;
        step();
        check_eq("prio_state", state, 2'b11);
        check_eq("prio_error", error, 0);
        check_eq("prio_gnt", fire_gnt, 0);
        reload_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("prio_rl_state", state, 2'b11);
            check_eq("prio_rl_error", error, 1);
            check_eq("prio_rl_gnt", fire_gnt, 0);
        end
        step();
        check_eq("prio_idle", state, 2'b00);
        check_eq("prio_sat_ammo", ammo_count, 500);
        check_eq("prio_idle_error", error, 1);
        fire_rate = 9'd0;
        step();
        check_eq("zero_rate_state", state, 2'b01);
        check_eq("zero_rate_gnt", fire_gnt, 3'b100);
        check_eq("zero_rate_error", error, 0);
        fire_req = '0;
        step();
        check_eq("zero_rate_ammo", ammo_count, 499);
        step(); step();
        check_eq("zero_rate_idle", state, 2'b00);

        // Reset in the middle of a reload
        reload_req = 1'b1; reload_amount = 9'd1;
        step();
        check_eq("midrl_enter", state, 2'b11);
        reload_req = 1'b0;
        step();
        check_eq("midrl_second", state, 2'b11);
        rst = 1'b0; fire_req = 3'b010;
        step();
        check_eq("midrl_state", state, 2'b00);
        check_eq("midrl_ammo", ammo_count, 0);
        check_eq("midrl_gnt", fire_gnt, 0);
        check_eq("midrl_error", error, 0);
        rst = 1'b1; fire_req = '0;
        step();
        check_eq("midrl_discarded", state, 2'b00);
        check_eq("midrl_ammo_after", ammo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
